// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single dmemory data port between the pipeline memory stage
// (fixed priority) and an auxiliary req/ack requester that has starvation protection.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_valid,
    input  logic        core_we,
    input  logic [1:0]  core_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [1:0]  aux_size,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    output logic        aux_ack,
    output logic        aux_err,
    output logic [31:0] aux_rdata,
    output logic        dmem_read_write,
    output logic [1:0]  dmem_access_size,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_data_in,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_ACK = 1'b1
    } state_t;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_next;
    logic        r_aux_err;
    logic [31:0] r_aux_rdata;

    logic        w_aligned;
    logic        w_in_arb;
    logic        w_aux_go;
    logic        w_aux_bad;

    // Size 11 has no legal alignment and is always rejected.
    always_comb begin
        w_aligned = 1'b0;
        case (aux_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~aux_addr[0];
            2'b10:   w_aligned = (aux_addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_in_arb  = (r_state == ST_ARB);
    assign w_aux_go  = reset && w_in_arb && aux_req && w_aligned &&
                       (!core_valid || (r_wait_cnt == LP_MAX_WAIT));
    assign w_aux_bad = reset && w_in_arb && aux_req && !w_aligned;

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        case (r_state)
            ST_ARB: begin
                if (w_aux_go || w_aux_bad) begin
                    w_state_next = ST_ACK;
                end
                if (!aux_req || w_aux_go) begin
                    w_wait_next = 8'd0;
                end else if (w_aligned && core_valid && (r_wait_cnt < LP_MAX_WAIT)) begin
                    w_wait_next = r_wait_cnt + 8'd1;
                end
            end
            ST_ACK: begin
                w_state_next = ST_ARB;
                w_wait_next  = 8'd0;
            end
            default: begin
                w_state_next = ST_ARB;
                w_wait_next  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_ARB;
            r_wait_cnt  <= 8'd0;
            r_aux_err   <= 1'b0;
            r_aux_rdata <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_aux_go || w_aux_bad) begin
                r_aux_err <= w_aux_bad;
            end
            if (w_aux_go && !aux_we) begin
                r_aux_rdata <= dmem_rdata;
            end
        end
    end

    // Writes are suppressed throughout reset so no stray store reaches memory.
    assign dmem_read_write  = reset && (w_aux_go ? aux_we : (core_valid && core_we));
    assign dmem_access_size = w_aux_go ? aux_size  : core_size;
    assign dmem_address     = w_aux_go ? aux_addr  : core_addr;
    assign dmem_data_in     = w_aux_go ? aux_wdata : core_wdata;

    assign core_rdata = dmem_rdata;
    assign core_stall = core_valid && w_aux_go;
    assign aux_ack    = (r_state == ST_ACK);
    assign aux_err    = aux_ack && r_aux_err;
    assign aux_rdata  = r_aux_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a word-addressed memory model stands in for dmemory,
// inputs change 1ns after the rising edge and outputs are checked on the falling edge.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        core_valid;
    logic        core_we;
    logic [1:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        aux_req;
    logic        aux_we;
    logic [1:0]  aux_size;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic        aux_ack;
    logic        aux_err;
    logic [31:0] aux_rdata;
    logic        dmem_read_write;
    logic [1:0]  dmem_access_size;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_rdata;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    logic [31:0] mem [0:63];

    dmem_arbiter #(.MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .core_valid(core_valid), .core_we(core_we), .core_size(core_size),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_stall(core_stall),
        .aux_req(aux_req), .aux_we(aux_we), .aux_size(aux_size),
        .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack), .aux_err(aux_err), .aux_rdata(aux_rdata),
        .dmem_read_write(dmem_read_write), .dmem_access_size(dmem_access_size),
        .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
        .dmem_rdata(dmem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign dmem_rdata = mem[dmem_address[7:2]];

    always @(posedge clock) begin
        if (dmem_read_write) begin
            mem[dmem_address[7:2]] <= dmem_data_in;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic core_set(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        core_valid = v; core_we = we; core_size = 2'b10; core_addr = a; core_wdata = d;
    endtask

    task automatic aux_set(input logic rq, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
        aux_req = rq; aux_we = we; aux_size = sz; aux_addr = a; aux_wdata = d;
    endtask

    initial begin
        reset = 1'b0;
        core_set(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        aux_set(1'b1, 1'b1, 2'b10, 32'h14, 32'h00000BAD);

        // Reset held with both requesters active: nothing may reach memory.
        @(negedge clock);
        chk("rst_rw_both", {31'd0, dmem_read_write}, 32'd0);
        chk("rst_stall", {31'd0, core_stall}, 32'd0);
        chk("rst_ack", {31'd0, aux_ack}, 32'd0);
        chk("rst_err", {31'd0, aux_err}, 32'd0);
        chk("rst_rdata", aux_rdata, 32'd0);
        chk("rst_wait", {24'd0, dut.r_wait_cnt}, 32'd0);
        next_cycle();
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        chk("rst_rw_aux_idle", {31'd0, dmem_read_write}, 32'd0);
        chk("rst_ack2", {31'd0, aux_ack}, 32'd0);
        next_cycle();
        chk("rst_no_writes", wr_cnt, 32'd0);

        // Release, then core store and same-cycle load of 0x10.
        reset = 1'b1;
        aux_set(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        core_set(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clock);
        chk("core_st_rw", {31'd0, dmem_read_write}, 32'd1);
        chk("core_st_stall", {31'd0, core_stall}, 32'd0);
        next_cycle();
        core_set(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clock);
        chk("core_ld_data", core_rdata, 32'hDEADBEEF);
        chk("core_ld_rw", {31'd0, dmem_read_write}, 32'd0);
        next_cycle();

        // Idle aux word write then read back of 0x20.
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        aux_set(1'b1, 1'b1, 2'b10, 32'h20, 32'h12345678);
        @(negedge clock);
        chk("auxw_rw", {31'd0, dmem_read_write}, 32'd1);
        chk("auxw_addr", dmem_address, 32'h20);
        chk("auxw_noack", {31'd0, aux_ack}, 32'd0);
        next_cycle();
        aux_set(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        @(negedge clock);
        chk("auxw_ack", {31'd0, aux_ack}, 32'd1);
        chk("auxw_err", {31'd0, aux_err}, 32'd0);
        next_cycle();
        aux_set(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
        @(negedge clock);
        chk("auxr_noack", {31'd0, aux_ack}, 32'd0);
        next_cycle();
        aux_set(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        @(negedge clock);
        chk("auxr_ack", {31'd0, aux_ack}, 32'd1);
        chk("auxr_err", {31'd0, aux_err}, 32'd0);
        chk("auxr_rdata", aux_rdata, 32'h12345678);
        next_cycle();
        @(negedge clock);
        chk("auxr_ack_gone", {31'd0, aux_ack}, 32'd0);
        chk("auxr_rdata_held", aux_rdata, 32'h12345678);
        next_cycle();

        // Starvation: core loads 0x20 every cycle, aux read of 0x10 from cycle 1.
        for (int c = 1; c <= 6; c++) begin
            core_set(1'b1, 1'b0, 32'h20, 32'h0);
            aux_set((c <= 5) ? 1'b1 : 1'b0, 1'b0, 2'b10, 32'h10, 32'h0);
            @(negedge clock);
            chk($sformatf("starve_stall_c%0d", c), {31'd0, core_stall}, {31'd0, c == 5});
            chk($sformatf("starve_ack_c%0d", c), {31'd0, aux_ack}, {31'd0, c == 6});
            chk($sformatf("starve_addr_c%0d", c), dmem_address, (c == 5) ? 32'h10 : 32'h20);
            if (c == 6) begin
                chk("starve_core_ld", core_rdata, 32'h12345678);
                chk("starve_aux_rdata", aux_rdata, 32'hDEADBEEF);
            end
            next_cycle();
        end

        // Misaligned half-word read at 0x21 while the core loads.
        core_set(1'b1, 1'b0, 32'h20, 32'h0);
        aux_set(1'b1, 1'b0, 2'b01, 32'h21, 32'h0);
        @(negedge clock);
        chk("mis_h_stall", {31'd0, core_stall}, 32'd0);
        chk("mis_h_rw", {31'd0, dmem_read_write}, 32'd0);
        chk("mis_h_addr", dmem_address, 32'h20);
        next_cycle();
        aux_set(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        @(negedge clock);
        chk("mis_h_ack", {31'd0, aux_ack}, 32'd1);
        chk("mis_h_err", {31'd0, aux_err}, 32'd1);
        chk("mis_h_stall2", {31'd0, core_stall}, 32'd0);
        next_cycle();

        // Size 11 write with the core idle: rejected, nothing written.
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        aux_set(1'b1, 1'b1, 2'b11, 32'h20, 32'hFFFFFFFF);
        @(negedge clock);
        chk("mis_s3_rw", {31'd0, dmem_read_write}, 32'd0);
        next_cycle();
        aux_set(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        @(negedge clock);
        chk("mis_s3_ack", {31'd0, aux_ack}, 32'd1);
        chk("mis_s3_err", {31'd0, aux_err}, 32'd1);
        chk("mis_s3_mem", mem[8], 32'h12345678);
        next_cycle();

        // Back-to-back: request held for 6 cycles with the core idle.
        for (int c = 1; c <= 7; c++) begin
            aux_set((c <= 6) ? 1'b1 : 1'b0, 1'b0, 2'b10, 32'h20, 32'h0);
            @(negedge clock);
            chk($sformatf("b2b_ack_c%0d", c), {31'd0, aux_ack}, {31'd0, (c % 2) == 0 && c <= 6});
            chk($sformatf("b2b_grant_c%0d", c), dmem_address,
                ((c % 2) == 1 && c <= 6) ? 32'h20 : 32'h0);
            next_cycle();
        end

        // Reset asserted in the middle of an ACK cycle.
        aux_set(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        next_cycle();
        aux_set(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        @(negedge clock);
        chk("mid_ack_before", {31'd0, aux_ack}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_ack_dropped", {31'd0, aux_ack}, 32'd0);
        chk("mid_wait", {24'd0, dut.r_wait_cnt}, 32'd0);
        chk("mid_rdata", aux_rdata, 32'd0);
        next_cycle();
        reset = 1'b1;
        aux_set(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
        @(negedge clock);
        chk("mid_arb_grant", dmem_address, 32'h20);
        chk("mid_arb_noack", {31'd0, aux_ack}, 32'd0);
        next_cycle();
        aux_set(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        @(negedge clock);
        chk("mid_reissue_ack", {31'd0, aux_ack}, 32'd1);
        chk("mid_reissue_rdata", aux_rdata, 32'h12345678);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
